// File: rtl/disp_pkg.sv
// Shared constants, state type and source-selection helpers for the
// metric display scheduler.
package disp_pkg;

    localparam int NUM_SRC = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    typedef enum logic {IDLE, RUN} state_t;

    function automatic logic [1:0] lowestEnabled(input logic [NUM_SRC-1:0] en);
        lowestEnabled = 2'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (en[i]) lowestEnabled = 2'(i);
        end
    endfunction

    // Round-robin from cur+1; offset 4 wraps back onto cur itself.
    function automatic logic [1:0] nextEnabled(input logic [1:0] cur,
                                               input logic [NUM_SRC-1:0] en);
        logic [1:0] idx;
        nextEnabled = cur;
        for (int i = NUM_SRC; i >= 1; i--) begin
            idx = cur + 2'(i);
            if (en[idx]) nextEnabled = idx;
        end
    endfunction

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational BCD nibble to active-low seven-segment pattern; values
// above 9 show a dash.
module bcd_seg_decode
    import disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/metric_display_scheduler.sv
// Time-shares one 4-digit seven-segment display between four metric sources,
// rotating per whole-second slot and scanning a once-per-second snapshot.
module metric_display_scheduler
    import disp_pkg::*;
#(
    parameter int SLOT_SECONDS = 2,
    parameter int REFRESH_DIV  = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        sec_tick,
    input  logic        hold,
    input  logic [3:0]  src_en,
    input  logic [15:0] src0_bcd,
    input  logic [15:0] src1_bcd,
    input  logic [15:0] src2_bcd,
    input  logic [15:0] src3_bcd,
    input  logic [3:0]  dp_src,
    output logic [3:0]  anode,
    output logic [6:0]  segment,
    output logic        dp,
    output logic [1:0]  cur_src,
    output logic        slot_start,
    output state_t      stateDbg
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_DIV - 1);
    localparam logic [3:0]    SLOT_LAST = 4'(SLOT_SECONDS - 1);

    state_t         state, stateNext;
    logic           paused, pausedNext;
    logic [1:0]     curNext;
    logic [3:0]     slotCnt, slotCntNext;
    logic [RW-1:0]  refCnt, refCntNext;
    logic [1:0]     digIdx, digIdxNext;
    logic [15:0]    snapVal;
    logic           snapDp;
    logic           slotStartNext;
    logic           load;
    logic [1:0]     loadSel;
    logic [15:0]    srcBcd [NUM_SRC];
    logic [3:0]     nibble;
    logic [6:0]     segRaw;
    logic [15:0]    upperDigits;
    logic           digitBlank;

    assign srcBcd[0] = src0_bcd;
    assign srcBcd[1] = src1_bcd;
    assign srcBcd[2] = src2_bcd;
    assign srcBcd[3] = src3_bcd;
    assign stateDbg  = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            paused     <= 1'b0;
            cur_src    <= 2'd0;
            slotCnt    <= 4'd0;
            refCnt     <= '0;
            digIdx     <= 2'd0;
            snapVal    <= 16'd0;
            snapDp     <= 1'b0;
            slot_start <= 1'b0;
        end else begin
            state      <= stateNext;
            paused     <= pausedNext;
            cur_src    <= curNext;
            slotCnt    <= slotCntNext;
            refCnt     <= refCntNext;
            digIdx     <= digIdxNext;
            slot_start <= slotStartNext;
            if (load) begin
                snapVal <= srcBcd[loadSel];
                snapDp  <= dp_src[loadSel];
            end
        end
    end

    always_comb begin
        stateNext     = state;
        pausedNext    = paused;
        curNext       = cur_src;
        slotCntNext   = slotCnt;
        refCntNext    = '0;
        digIdxNext    = 2'd0;
        slotStartNext = 1'b0;
        load          = 1'b0;
        loadSel       = cur_src;
        case (state)
            IDLE: begin
                pausedNext  = 1'b0;
                slotCntNext = 4'd0;
                if (start && (src_en != 4'd0)) begin
                    stateNext     = RUN;
                    curNext       = lowestEnabled(src_en);
                    loadSel       = curNext;
                    load          = 1'b1;
                    slotStartNext = 1'b1;
                end
            end
            RUN: begin
                refCntNext = (refCnt == REF_LAST) ? '0 : refCnt + 1'b1;
                digIdxNext = (refCnt == REF_LAST) ? digIdx + 2'd1 : digIdx;
                if (!start) begin
                    stateNext   = IDLE;
                    pausedNext  = 1'b0;
                    slotCntNext = 4'd0;
                    refCntNext  = '0;
                    digIdxNext  = 2'd0;
                end else if (src_en == 4'd0) begin
                    pausedNext  = 1'b1;
                    slotCntNext = 4'd0;
                end else if (paused) begin
                    // Returning from an all-disabled pause restarts at the lowest source.
                    pausedNext    = 1'b0;
                    curNext       = lowestEnabled(src_en);
                    loadSel       = curNext;
                    load          = 1'b1;
                    slotStartNext = 1'b1;
                    slotCntNext   = 4'd0;
                end else if (!src_en[cur_src] ||
                             (sec_tick && !hold && slotCnt >= SLOT_LAST)) begin
                    curNext       = nextEnabled(cur_src, src_en);
                    loadSel       = curNext;
                    load          = 1'b1;
                    slotStartNext = 1'b1;
                    slotCntNext   = 4'd0;
                end else if (sec_tick) begin
                    load = 1'b1;
                    if (!hold) slotCntNext = slotCnt + 4'd1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign nibble      = snapVal[{digIdx, 2'b00} +: 4];
    assign upperDigits = snapVal >> {digIdx, 2'b00};
    assign digitBlank  = (digIdx != 2'd0) && !(digIdx == 2'd1 && snapDp) &&
                         (upperDigits == 16'd0);

    bcd_seg_decode uDecode (
        .bcd (nibble),
        .seg (segRaw)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            anode   <= 4'hF;
            segment <= SEG_BLANK;
            dp      <= 1'b1;
        end else if (state == RUN && !paused) begin
            anode   <= ~(4'b0001 << digIdx);
            segment <= digitBlank ? SEG_BLANK : segRaw;
            dp      <= !(digIdx == 2'd1 && snapDp);
        end else begin
            anode   <= 4'hF;
            segment <= SEG_BLANK;
            dp      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_metric_display_scheduler.sv
// Directed bench for metric_display_scheduler: slot-start scoreboard plus
// scan and blanking checks with hand-computed expectations.
module tb_metric_display_scheduler;
    import disp_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        sec_tick = 1'b0;
    logic        hold = 1'b0;
    logic [3:0]  src_en = 4'd0;
    logic [15:0] src0_bcd = 16'd0;
    logic [15:0] src1_bcd = 16'd0;
    logic [15:0] src2_bcd = 16'd0;
    logic [15:0] src3_bcd = 16'd0;
    logic [3:0]  dp_src = 4'd0;
    logic [3:0]  anode;
    logic [6:0]  segment;
    logic        dp;
    logic [1:0]  cur_src;
    logic        slot_start;
    state_t      stateDbg;

    int total = 0;
    int bad = 0;
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    metric_display_scheduler #(.SLOT_SECONDS(2), .REFRESH_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .sec_tick   (sec_tick),
        .hold       (hold),
        .src_en     (src_en),
        .src0_bcd   (src0_bcd),
        .src1_bcd   (src1_bcd),
        .src2_bcd   (src2_bcd),
        .src3_bcd   (src3_bcd),
        .dp_src     (dp_src),
        .anode      (anode),
        .segment    (segment),
        .dp         (dp),
        .cur_src    (cur_src),
        .slot_start (slot_start),
        .stateDbg   (stateDbg)
    );

    // Every slot_start pulse must match the next queued source index.
    always @(negedge clk) begin
        if (slot_start) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL slot_start: unexpected pulse, cur_src=%0d, nothing queued", cur_src);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                if (cur_src !== e) begin
                    bad++;
                    $display("FAIL slot_src: cur_src=%0d required=%0d", cur_src, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1 sec_tick = 1'b1;
        @(posedge clk);
        #1 sec_tick = 1'b0;
    endtask

    task automatic check_blank(input string name);
        check({name, "_anode"}, {12'd0, anode}, 16'h000F);
        check({name, "_seg"}, {9'd0, segment}, {9'd0, SEG_BLANK});
        check({name, "_dp"}, {15'd0, dp}, 16'd1);
    endtask

    task automatic scan_check(input string name, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dpn);
        logic [6:0] segs [4];
        logic [3:0] want;
        int n;
        segs[0] = s0;
        segs[1] = s1;
        segs[2] = s2;
        segs[3] = s3;
        for (int d = 0; d < 4; d++) begin
            want = ~(4'b0001 << d);
            n = 0;
            @(negedge clk);
            while (anode !== want && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (n >= 40) begin
                total++;
                bad++;
                $display("FAIL %s_timeout: digit %0d anode=%b never reached %b", name, d, anode, want);
            end else begin
                check($sformatf("%s_seg%0d", name, d), {9'd0, segment}, {9'd0, segs[d]});
                check($sformatf("%s_dp%0d", name, d), {15'd0, dp}, {15'd0, dpn[d]});
            end
        end
        #1;
    endtask

    initial begin
        src0_bcd = 16'h0042;
        src1_bcd = 16'h0005;
        src2_bcd = 16'h00A3;
        src3_bcd = 16'h1234;
        dp_src   = 4'b0010;
        cyc(3);
        check_blank("in_reset");
        reset = 1'b1;
        cyc(20);
        check_blank("idle");
        check("idle_src", {14'd0, cur_src}, 16'd0);
        check("idle_slot", {15'd0, slot_start}, 16'd0);
        check("idle_state", {15'd0, stateDbg}, {15'd0, IDLE});
        src_en = 4'hF;
        cyc(10);
        check_blank("idle_en");

        // Full rotation over four sources, 2 s per slot
        exp_q.push_back(2'd0);
        start = 1'b1;
        cyc(6);
        check("run_state", {15'd0, stateDbg}, {15'd0, RUN});
        for (int i = 1; i <= 8; i++) begin
            if (i % 2 == 0) exp_q.push_back(2'((i / 2) % 4));
            tick();
            cyc(4);
        end
        check("rot_end", {14'd0, cur_src}, 16'd0);
        scan_check("src0_42", SEG_2, SEG_4, SEG_BLANK, SEG_BLANK, 4'b1111);

        exp_q.push_back(2'd1);
        tick(); tick(); cyc(2);
        scan_check("src1_0p5", SEG_5, SEG_0, SEG_BLANK, SEG_BLANK, 4'b1101);
        exp_q.push_back(2'd2);
        tick(); tick(); cyc(2);
        scan_check("src2_dash", SEG_3, SEG_DASH, SEG_BLANK, SEG_BLANK, 4'b1111);
        exp_q.push_back(2'd3);
        tick(); tick(); cyc(2);
        scan_check("src3_1234", SEG_4, SEG_3, SEG_2, SEG_1, 4'b1111);
        exp_q.push_back(2'd0);
        tick(); tick(); cyc(2);

        // Hold freezes rotation; snapshot still refreshes on each tick
        hold = 1'b1;
        repeat (5) begin
            tick();
            cyc(3);
        end
        check("hold_src", {14'd0, cur_src}, 16'd0);
        src0_bcd = 16'h0917;
        cyc(4);
        scan_check("hold_old", SEG_2, SEG_4, SEG_BLANK, SEG_BLANK, 4'b1111);
        tick();
        cyc(2);
        scan_check("hold_new", SEG_7, SEG_1, SEG_9, SEG_BLANK, 4'b1111);
        check("hold_src2", {14'd0, cur_src}, 16'd0);
        hold = 1'b0;

        // Sparse enables: current source dropped, then 1,3,1,3 rotation
        exp_q.push_back(2'd1);
        src_en = 4'b1010;
        cyc(2);
        check("drop_cur", {14'd0, cur_src}, 16'd1);
        exp_q.push_back(2'd3);
        tick(); tick(); cyc(2);
        exp_q.push_back(2'd1);
        tick(); tick(); cyc(2);
        exp_q.push_back(2'd3);
        tick(); tick(); cyc(2);
        tick();
        cyc(2);
        exp_q.push_back(2'd1);
        src_en = 4'b0010;
        @(posedge clk);
        #1;
        check("disable_mid", {14'd0, cur_src}, 16'd1);
        exp_q.push_back(2'd1);
        tick(); tick(); cyc(2);
        check("reselect", {14'd0, cur_src}, 16'd1);

        // All sources disabled blanks; resume at lowest enabled
        src_en = 4'd0;
        cyc(6);
        check_blank("pause");
        check("pause_src", {14'd0, cur_src}, 16'd1);
        exp_q.push_back(2'd2);
        src_en = 4'b1100;
        cyc(2);
        check("resume_src", {14'd0, cur_src}, 16'd2);

        // Asynchronous reset mid-scan
        cyc(3);
        reset = 1'b0;
        #1;
        check_blank("reset_mid");
        check("reset_src", {14'd0, cur_src}, 16'd0);
        check("reset_slot", {15'd0, slot_start}, 16'd0);
        start = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(10);
        check_blank("post_reset");

        // Start coinciding with a tick: counter starts at 0
        @(posedge clk);
        exp_q.push_back(2'd2);
        #1;
        start = 1'b1;
        sec_tick = 1'b1;
        @(posedge clk);
        #1 sec_tick = 1'b0;
        cyc(3);
        tick();
        cyc(2);
        check("start_tick_cnt", {14'd0, cur_src}, 16'd2);
        exp_q.push_back(2'd3);
        tick();
        cyc(2);
        start = 1'b0;
        cyc(3);
        check_blank("stop");
        check("stop_state", {15'd0, stateDbg}, {15'd0, IDLE});

        cyc(5);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL slot_queue: %0d expected slot_start pulses never seen, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/metric_display_scheduler.md
# metric_display_scheduler

Time-shares the single 4-digit seven-segment display between the four fitness metric sources (step count, distance, speed check, high-activity time). It rotates the displayed source on a whole-second schedule, skips disabled sources, snapshots the selected value once per second so digits do not flicker, and scans the digits with leading-zero blanking and a decimal point. It sits between the metric counters and the board `anode`/`segment` pins and replaces per-metric display FSMs plus an output mux.

## Interface
Parameters:
- `SLOT_SECONDS`, default 2: seconds each source stays on the display. Legal range is 1..15.
- `REFRESH_DIV`, default 100000: `clk` cycles per digit. At 100 MHz this gives a 1 kHz digit rate.

Ports:
- `clk` in 1: system clock. All state is on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: level. High = run; low = idle/blank.
- `sec_tick` in 1: one-`clk` pulse per second from the pulse generator.
- `hold` in 1: level. Freezes rotation on the current source.
- `src_en` in 4: per-source enable. Bit i enables source i.
- `src0_bcd`..`src3_bcd` in 16 each: 4-digit BCD values. Nibble 3 is the most significant digit.
- `dp_src` in 4: bit i set = source i is shown with a decimal point on digit 1 (xx.x format).
- `anode` out 4: active-low, one-hot. `anode[0]` = rightmost digit.
- `segment` out 7: active-low. Bit order is `{g,f,e,d,c,b,a}`.
- `dp` out 1: active-low decimal point.
- `cur_src` out 2: index of the source currently displayed.
- `slot_start` out 1: one-cycle pulse when a slot begins.

## Operation
- The FSM has two states, IDLE and RUN.
- **IDLE**
  - `anode`=4'hF, `segment`=7'h7F, `dp`=1.
  - Scan divider and slot counter held at 0.
- **IDLE→RUN** on `start`=1 with at least one `src_en` bit set:
  - `cur_src` = lowest enabled index.
  - Snapshot register loaded; `slot_start` pulses.
- **RUN→IDLE** when `start`=0.
  - If `src_en`=0 while in RUN, the display blanks and `cur_src` holds; it resumes at the lowest enabled index when an enable returns.
- **Slot counter** (4 bits): increments on `sec_tick` unless `hold`=1.
  - A tick arriving with counter == `SLOT_SECONDS-1` advances the slot and clears the counter.
- **Advance**: round-robin search from `cur_src+1` modulo 4, taking the first enabled source.
  - If only the current source is enabled it is reselected, and `slot_start` still pulses.
- **Current source disabled mid-slot**: the block advances on the next cycle, irrespective of `hold`.
- **Snapshot**: the selected `srcN_bcd` (and its `dp_src` bit) is latched at every slot start and on every `sec_tick`. The digits show only the snapshot.
- **Scan**: the refresh counter wraps at `REFRESH_DIV-1`; the digit index (0..3) increments and wraps 3→0.
- **Digit decode**
  - BCD 0-9 uses the standard patterns (0 → 7'b1000000).
  - A nibble >9 shows a dash (7'b0111111).
- **Leading-zero blanking**: zero digits above the most significant nonzero digit are blanked.
  - Digit 0 is never blanked.
  - When the snapshot dp bit is set, digit 1 is also never blanked, so 0005 displays "0.5".
- **Decimal point**: `dp`=0 only while digit 1 is scanned and the snapshot dp bit is set.

## Timing
- **Reset values**: `anode`=4'hF, `segment`=7'h7F, `dp`=1, `cur_src`=0, `slot_start`=0, state IDLE, all counters 0.
- **Registered outputs**: `anode`, `segment` and `dp` update 1 cycle after a digit-index change or snapshot load.
- **Start latency**: from the `start` rise, `slot_start` and `cur_src` are valid the next cycle, and the first digit is driven the cycle after that.
- **Slot change**: `cur_src` and `slot_start` change 1 cycle after the terminal `sec_tick`. The first digit of the new source appears 1 cycle later.
- **Simultaneous events**
  - `start` rise with `sec_tick`: start wins and the counter is 0.
  - `hold` with `sec_tick`: no count, but the snapshot is still refreshed.
  - A `src_en` change in the same cycle as an advance: the new `src_en` is used.
- **Reset mid-operation**: immediate blank; no `slot_start` pulse is emitted on reset exit.

## Structure
- Package `disp_pkg` contains:
  - `NUM_SRC`=4
  - `SEG_BLANK`=7'h7F
  - `SEG_DASH`=7'b0111111
  - the digit-0..9 segment constants
  - the state enum {IDLE, RUN}
- Sub-module `bcd_seg_decode`: combinational 4-bit BCD → 7-bit active-low segments, with dash for values >9. It is instantiated once, on the scanned nibble.

## Test plan
- Reset released, `start`=0 → `anode`=4'hF and `segment`=7'h7F indefinitely.
- `src_en`=4'b1111, `start`=1, 8 `sec_tick`s, `SLOT_SECONDS`=2 → `cur_src` sequence 0,1,2,3,0, with `slot_start` pulsed 5 times.
- `src_en`=4'b1010 → rotation 1,3,1. Clearing bit 3 mid-slot moves `cur_src` to 1 within 1 cycle.
- `src1_bcd`=16'h0005 with `dp_src[1]`=1, and `src0_bcd`=16'h0042 → scan shows "0.5" with digits 2-3 blank, and "42" with digits 2-3 blank.
- `hold`=1 across 5 `sec_tick`s → `cur_src` is unchanged. A source value change is visible after the next tick.
- `reset` asserted mid-scan, or `src2_bcd`=16'h00A3 → outputs blank immediately; the A nibble displays as a dash (7'b0111111).
